// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-FSM state type and divider/width helpers for the UART path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        DONE
    } uart_rx_state_t;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned tick_hz;
        int unsigned div;
        tick_hz = baud * oversample;
        div     = (clk_hz + tick_hz / 2) / tick_hz;
        return (div == 0) ? 1 : div;
    endfunction

    // Counter width able to hold 0..n-1, at least one bit.
    function automatic int unsigned uart_cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: emits a one-cycle tick every DIV clocks; clear restarts the phase.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW   = uart_cw(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter; clear aligns the first tick DIV clocks after the start edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampling UART receiver with majority voting, 5-9 data bits,
// 1-2 stop bits, valid/ready output register and overrun pulse.
// Optional parity checker enabled by defining UART_RX_PARITY_EN.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int unsigned DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned MID = OVERSAMPLE / 2;
    localparam int unsigned PW  = uart_cw(OVERSAMPLE);
    localparam int unsigned BW  = uart_cw(DATA_BITS);

    localparam logic [PW-1:0] PH_LAST   = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_S0     = PW'(MID - 1);
    localparam logic [PW-1:0] PH_S1     = PW'(MID);
    localparam logic [PW-1:0] PH_S2     = PW'(MID + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic                 sync1, sync2, line_prev;
    logic [1:0]           flush;
    logic                 fall, clear, tick;
    logic [PW-1:0]        phase, phase_nxt;
    logic                 s0, s1, maj, decide, ferr_now;
    uart_rx_state_t       state, state_nxt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;
`ifdef UART_RX_PARITY_EN
    logic                 perr;
`endif

    // Two-flop synchroniser plus edge register; the edge register stays 0 until
    // real line samples have flushed the reset 1s, so a line held low across
    // reset cannot look like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            flush     <= '0;
            line_prev <= 1'b0;
        end else begin
            sync1     <= rx_pin_in;
            sync2     <= sync1;
            flush     <= {flush[0], 1'b1};
            line_prev <= flush[1] & sync2;
        end
    end

    assign fall  = line_prev & ~sync2;
    assign clear = (state == IDLE) && fall;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    // Ticks elapsed since the start edge, modulo one bit; samples at mid-1, mid, mid+1.
    assign phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
    assign decide    = tick && (phase_nxt == PH_S2);
    assign maj       = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
    assign ferr_now  = (bit_cnt == '0) ? ~maj : ferr;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (fall) state_nxt = START;
            START:  if (decide) state_nxt = maj ? IDLE : DATA;
            DATA: begin
                if (decide && (bit_cnt == DATA_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (decide) state_nxt = STOP;
`endif
            STOP: begin
                if (decide && (bit_cnt == STOP_LAST)) begin
                    state_nxt = (ferr_now && !sync2) ? BREAK : DONE;
                end
            end
            BREAK:  if (sync2) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-phase counter, vote samples, shift register, bit counter and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
            ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr    <= 1'b0;
`endif
        end else begin
            if (clear) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase_nxt;
            end
            if (tick && (phase_nxt == PH_S0)) s0 <= sync2;
            if (tick && (phase_nxt == PH_S1)) s1 <= sync2;
            if (decide) begin
                case (state)
                    START: bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: perr <= maj ^ (^shreg) ^ PARITY_ODD;
`endif
                    STOP: begin
                        if (bit_cnt == '0) ferr <= ~maj;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output register: load on DONE when empty or being drained, else drop and flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_overrun <= 1'b0;
            if (state == DONE) begin
                if (!rx_valid || rx_ready) begin
                    rx_data       <= shreg;
                    rx_valid      <= 1'b1;
                    rx_frame_err  <= ferr;
`ifdef UART_RX_PARITY_EN
                    rx_parity_err <= perr;
`endif
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    // PARITY_ODD has no effect without the parity checker.
    assign rx_parity_err = PARITY_ODD & 1'b0;
`endif

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Parametrised UART receive engine, the next-generation replacement for the fixed 8N1 receiver in the UART path. It detects start bits itself, oversamples the line with majority voting, and supports 5–9 data bits, optional parity and 1 or 2 stop bits. It delivers each frame through a valid/ready handshake with per-frame error flags and an overrun indication. It sits between the synchronised `rx_pin_in` pad and the UART host/bus interface.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115_200, line bit rate.
- `OVERSAMPLE`, 16, ticks per bit; even, ≥8.
- `DATA_BITS`, 8, data width; legal 5–9.
- `STOP_BITS`, 1, legal 1 or 2.
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even; only meaningful with `UART_RX_PARITY_EN`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_pin_in` in 1: asynchronous serial line, idle high.
- `rx_data` out `DATA_BITS`: received word, LSB = first bit on the line.
- `rx_valid` out 1: `rx_data` and the flags hold an unconsumed frame.
- `rx_ready` in 1: consumer accepts the frame on `rx_valid && rx_ready`.
- `rx_frame_err` out 1: first stop bit sampled 0; qualified by `rx_valid`.
- `rx_parity_err` out 1: parity mismatch; qualified by `rx_valid`; tied 0 when parity is compiled out.
- `rx_overrun` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- Input path: 2-flop synchroniser on `rx_pin_in`, both flops reset to 1.
- Tick generator: `DIV = round(CLK_HZ/(BAUD*OVERSAMPLE))`. It emits a 1-cycle `tick` every `DIV` clocks. Its counter restarts on the start-edge detect so phase aligns to the edge.
- FSM states and transitions:
  - IDLE: a synchronised 1→0 transition moves to START and clears the tick counter.
  - START: at tick `OVERSAMPLE/2` the start bit is majority-sampled.
    - Result 1 is a false start: return to IDLE.
    - Result 0: move to DATA with `bit_cnt=0`.
  - DATA: every `OVERSAMPLE` ticks, at the bit midpoint, shift the majority sample into the shift register, LSB first. After `DATA_BITS` bits, go to PARITY if enabled, else to STOP.
  - PARITY: sample one bit and compare with the XOR of the data bits (XNOR if `PARITY_ODD`). Then go to STOP.
  - STOP: sample `STOP_BITS` stop bits. Only the first stop bit sets the frame error.
    - Frame error, line still 0: go to BREAK.
    - Otherwise: go to DONE.
  - BREAK: wait for the synchronised line = 1, then go to DONE.
  - DONE: one cycle. Load the output register, then return to IDLE.
- Majority vote: 2-of-3 over the samples at ticks `mid-1`, `mid` and `mid+1`, where `mid = OVERSAMPLE/2`.
- Output register:
  - DONE with `rx_valid=0` (or being consumed that same cycle): load `rx_data` and the error flags, and set `rx_valid`.
  - DONE with `rx_valid=1` and no handshake that cycle: keep the old frame, drop the new one, pulse `rx_overrun`.
  - `rx_valid && rx_ready`: clear `rx_valid` next cycle. Data and flags are held until the next load.
- Reset values: `rx_data=0`, `rx_valid=0`, `rx_frame_err=0`, `rx_parity_err=0`, `rx_overrun=0`, FSM in IDLE. Any frame in progress is discarded.
- Reset mid-frame: the engine re-arms only on a fresh 1→0 edge after reset.

## Timing
- Edge to START: 3 clocks (2 synchroniser stages plus the edge register).
- `rx_valid` rises 2 clocks after the midpoint tick of the last stop bit (the STOP→DONE cycle plus the DONE load).
- Back-to-back frames with zero idle are supported. The next start edge is detected while the FSM is in IDLE after DONE, because the last stop bit ends ½ bit after the last sample.
- Handshake: when the consumer holds `rx_ready=1`, each frame is accepted in the cycle `rx_valid` first rises. Throughput is 1 frame per frame-time with no loss.
- Frame length in ticks: `OVERSAMPLE × (1 + DATA_BITS + P + STOP_BITS)`, where `P` is 1 if parity is present, else 0.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state, `PARITY_ODD` and the parity checker are present.
  - The frame carries one parity bit after the data.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `rx_parity_err` is tied 0 and `PARITY_ODD` is ignored.

## Structure
- `uart_pkg` holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK, DONE);
  - a function computing `DIV` from `CLK_HZ`, `BAUD` and `OVERSAMPLE`;
  - width helper constants (`$clog2` of `DIV` and of `DATA_BITS`).
- One sub-module: `uart_baud_tick`, a parametrised divider with `clear` input and `tick` output.

## Test plan
- 8N1, CLK_HZ=50e6, BAUD=115200 (DIV=27): send 0xA5 → `rx_data=0xA5`, `rx_valid` 1, both error flags 0.
- 0.25-bit low glitch on idle line → return to IDLE, no `rx_valid`; then 0x3C is received correctly.
- `UART_RX_PARITY_EN`, even parity, DATA_BITS=7: send 0x55 with parity 1 → `rx_parity_err=1`, `rx_data=0x55`.
- Stop bit forced 0 and line held low for 3 bit-times → `rx_frame_err=1` with data 0x00. The next frame 0x81 is received only after the line returns high.
- `rx_ready=0`, two back-to-back frames 0x11 then 0x22 → `rx_data` stays 0x11, `rx_overrun` pulses 1 cycle; after accepting, `rx_valid=0`.
- Assert `rst` during DATA bit 4 → all outputs 0 next cycle; frame 0x7E sent after release is received intact.
